// File: rtl/ps2_note_decoder_if.sv
// Byte stream from PS2_Controller: one received byte plus its one-cycle valid strobe.
interface ps2_note_decoder_if;
  logic [7:0] received_data;
  logic       received_data_en;

  modport master (output received_data, received_data_en);
  modport slave  (input  received_data, received_data_en);
endinterface

// File: rtl/ps2_note_decoder.sv
// PS/2 set-2 scancode parser: E0/F0 prefix FSM producing held-note bitmap,
// note on/off pulses, saturating octave offset and flat/sharp toggles.
module ps2_note_decoder #(
  parameter int OCT_MIN        = -4,
  parameter int OCT_MAX        = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  ps2_note_decoder_if.slave        ps2,
  input  logic                     clear,
  output logic [6:0]               note_held,
  output logic                     note_on,
  output logic                     note_off,
  output logic [2:0]               note_idx,
  output logic [3:0]               octave,
  output logic                     flat,
  output logic                     sharp,
  output logic                     prefix_pending
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]    TLAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [3:0] OMIN = 4'(OCT_MIN);
  localparam logic signed [3:0] OMAX = 4'(OCT_MAX);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t        state;
  logic [3:0]    arrow_held;
  logic [CW-1:0] tcount;

  logic       is_note;
  logic [2:0] code_idx;
  logic [6:0] note_bit;
  logic       is_arrow;
  logic [1:0] arrow_idx;

  always_comb begin
    is_note  = 1'b1;
    code_idx = '0;
    case (ps2.received_data)
      8'h16:   code_idx = 3'd0;
      8'h1E:   code_idx = 3'd1;
      8'h26:   code_idx = 3'd2;
      8'h25:   code_idx = 3'd3;
      8'h2E:   code_idx = 3'd4;
      8'h36:   code_idx = 3'd5;
      8'h3D:   code_idx = 3'd6;
      default: is_note  = 1'b0;
    endcase
    note_bit = 7'b1000000 >> code_idx;

    // arrow_idx: 0=up, 1=down, 2=left, 3=right
    is_arrow  = 1'b1;
    arrow_idx = '0;
    case (ps2.received_data)
      8'h75:   arrow_idx = 2'd0;
      8'h72:   arrow_idx = 2'd1;
      8'h6B:   arrow_idx = 2'd2;
      8'h74:   arrow_idx = 2'd3;
      default: is_arrow  = 1'b0;
    endcase
  end

  assign prefix_pending = (state != IDLE);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      note_held  <= '0;
      note_on    <= 1'b0;
      note_off   <= 1'b0;
      note_idx   <= '0;
      octave     <= '0;
      flat       <= 1'b0;
      sharp      <= 1'b0;
      arrow_held <= '0;
      tcount     <= '0;
    end else begin
      note_on  <= 1'b0;
      note_off <= 1'b0;
      if (clear) begin
        note_held  <= '0;
        arrow_held <= '0;
        state      <= IDLE;
        tcount     <= '0;
      end else if (ps2.received_data_en) begin
        tcount <= '0;
        if (ps2.received_data == 8'hF0 && state == IDLE) begin
          state <= BRK;
        end else if (ps2.received_data == 8'hF0 && state == EXT) begin
          state <= EXT_BRK;
        end else if (ps2.received_data == 8'hE0) begin
          state <= EXT;
        end else begin
          state <= IDLE;
          case (state)
            IDLE: begin
              if (is_note && !(|(note_held & note_bit))) begin
                note_held <= note_held | note_bit;
                note_on   <= 1'b1;
                note_idx  <= code_idx;
              end
            end
            BRK: begin
              if (is_note && (|(note_held & note_bit))) begin
                note_held <= note_held & ~note_bit;
                note_off  <= 1'b1;
                note_idx  <= code_idx;
              end
            end
            EXT: begin
              if (is_arrow && !arrow_held[arrow_idx]) begin
                arrow_held[arrow_idx] <= 1'b1;
                case (arrow_idx)
                  2'd0: if ($signed(octave) < OMAX) octave <= octave + 4'd1;
                  2'd1: if ($signed(octave) > OMIN) octave <= octave - 4'd1;
                  2'd2: flat  <= ~flat;
                  2'd3: sharp <= ~sharp;
                endcase
              end
            end
            EXT_BRK: begin
              if (is_arrow) arrow_held[arrow_idx] <= 1'b0;
            end
          endcase
        end
      end else if (state != IDLE) begin
        if (tcount == TLAST) begin
          state  <= IDLE;
          tcount <= '0;
        end else begin
          tcount <= tcount + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Scoreboard bench for ps2_note_decoder: expected pulses queued at stimulus time,
// checked by a pulse monitor; held/octave/flag state checked inline per scenario.
module tb_ps2_note_decoder;

  localparam int T = 64;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] note_held;
  logic       note_on, note_off;
  logic [2:0] note_idx;
  logic [3:0] octave;
  logic       flat, sharp, prefix_pending;

  int vectors = 0;
  int miscompares = 0;

  // entries are {is_off, idx}
  logic [3:0] exp_q[$];
  logic [3:0] exp_pop;

  int exp_oct = 0;
  logic exp_flat = 1'b0;
  logic exp_sharp = 1'b0;

  ps2_note_decoder_if bus ();

  ps2_note_decoder #(
    .OCT_MIN(-4),
    .OCT_MAX(4),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CLOCK_50(clk),
    .resetn(resetn),
    .ps2(bus.slave),
    .clear(clear),
    .note_held(note_held),
    .note_on(note_on),
    .note_off(note_off),
    .note_idx(note_idx),
    .octave(octave),
    .flat(flat),
    .sharp(sharp),
    .prefix_pending(prefix_pending)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (resetn && (note_on || note_off)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pulse_unexpected: got on=%0b off=%0b idx=%0d, required no pulse", note_on, note_off, note_idx);
      end else begin
        exp_pop = exp_q.pop_front();
        if ({note_on, note_off, note_idx} !== {~exp_pop[3], exp_pop[3], exp_pop[2:0]}) begin
          miscompares++;
          $display("FAIL pulse: got on=%0b off=%0b idx=%0d, required on=%0b off=%0b idx=%0d",
                   note_on, note_off, note_idx, ~exp_pop[3], exp_pop[3], exp_pop[2:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.received_data    = b;
    bus.received_data_en = 1'b1;
    @(negedge clk);
    bus.received_data_en = 1'b0;
  endtask

  task automatic press_ext(input logic [7:0] c);
    send_byte(8'hE0);
    send_byte(c);
  endtask

  task automatic release_ext(input logic [7:0] c);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(c);
  endtask

  task automatic release_note(input logic [7:0] c);
    send_byte(8'hF0);
    send_byte(c);
  endtask

  task automatic arrow_up();
    press_ext(8'h75);
    if (exp_oct < 4) exp_oct++;
  endtask

  task automatic arrow_down();
    press_ext(8'h72);
    if (exp_oct > -4) exp_oct--;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.received_data = 8'h00;
    bus.received_data_en = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({note_held, note_on, note_off, note_idx, octave, flat, sharp, prefix_pending} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got held=%b on=%b off=%b idx=%0d oct=%h flat=%b sharp=%b pend=%b, required all 0",
               note_held, note_on, note_off, note_idx, octave, flat, sharp, prefix_pending);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_typematic();
    exp_q.push_back({1'b0, 3'd0});
    send_byte(8'h16);
    vectors++;
    if (note_held !== 7'b1000000) begin
      miscompares++; $display("FAIL typ_make_held: got %b, required 1000000", note_held);
    end
    send_byte(8'h16);
    vectors++;
    if (note_held !== 7'b1000000) begin
      miscompares++; $display("FAIL typ_repeat_held: got %b, required 1000000", note_held);
    end
    send_byte(8'hF0);
    vectors++;
    if (prefix_pending !== 1'b1) begin
      miscompares++; $display("FAIL typ_brk_pending: got %b, required 1", prefix_pending);
    end
    exp_q.push_back({1'b1, 3'd0});
    send_byte(8'h16);
    vectors++;
    if (note_held !== 7'b0000000 || prefix_pending !== 1'b0) begin
      miscompares++; $display("FAIL typ_break: got held=%b pend=%b, required 0000000 0", note_held, prefix_pending);
    end
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL typ_drain: got %0d pulses missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_multi_notes();
    exp_q.push_back({1'b0, 3'd1});
    send_byte(8'h1E);
    vectors++;
    if (note_held !== 7'b0100000) begin
      miscompares++; $display("FAIL multi_b: got %b, required 0100000", note_held);
    end
    exp_q.push_back({1'b0, 3'd6});
    send_byte(8'h3D);
    vectors++;
    if (note_held !== 7'b0100001) begin
      miscompares++; $display("FAIL multi_bg: got %b, required 0100001", note_held);
    end
    exp_q.push_back({1'b1, 3'd1});
    release_note(8'h1E);
    vectors++;
    if (note_held !== 7'b0000001) begin
      miscompares++; $display("FAIL multi_rel_b: got %b, required 0000001", note_held);
    end
    // break of a key not held: silent
    release_note(8'h25);
    exp_q.push_back({1'b1, 3'd6});
    release_note(8'h3D);
    vectors++;
    if (note_held !== 7'b0000000) begin
      miscompares++; $display("FAIL multi_rel_g: got %b, required 0000000", note_held);
    end
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL multi_drain: got %0d pulses missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back({1'b0, 3'd2});
    exp_q.push_back({1'b0, 3'd3});
    exp_q.push_back({1'b0, 3'd4});
    @(negedge clk);
    bus.received_data_en = 1'b1;
    bus.received_data = 8'h26; @(negedge clk);
    bus.received_data = 8'h25; @(negedge clk);
    bus.received_data = 8'h2E; @(negedge clk);
    bus.received_data_en = 1'b0;
    vectors++;
    if (note_held !== 7'b0011100) begin
      miscompares++; $display("FAIL b2b_held: got %b, required 0011100", note_held);
    end
    exp_q.push_back({1'b1, 3'd2});
    exp_q.push_back({1'b1, 3'd3});
    exp_q.push_back({1'b1, 3'd4});
    bus.received_data_en = 1'b1;
    bus.received_data = 8'hF0; @(negedge clk);
    bus.received_data = 8'h26; @(negedge clk);
    bus.received_data = 8'hF0; @(negedge clk);
    bus.received_data = 8'h25; @(negedge clk);
    bus.received_data = 8'hF0; @(negedge clk);
    bus.received_data = 8'h2E; @(negedge clk);
    bus.received_data_en = 1'b0;
    @(negedge clk);
    vectors++;
    if (note_held !== 7'b0000000 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL b2b_release: got held=%b pending_exp=%0d, required 0000000 0", note_held, exp_q.size());
    end
  endtask

  task automatic test_octave();
    for (int i = 1; i <= 6; i++) begin
      arrow_up();
      vectors++;
      if (octave !== 4'(exp_oct)) begin
        miscompares++; $display("FAIL oct_up%0d: got %h, required %h", i, octave, 4'(exp_oct));
      end
      release_ext(8'h75);
    end
    // up again then re-pressed without a break: only the first counts
    exp_oct = 3;
    press_ext(8'h72);
    release_ext(8'h72);
    press_ext(8'h75);
    press_ext(8'h75);
    exp_oct = 4;
    vectors++;
    if (octave !== 4'(exp_oct)) begin
      miscompares++; $display("FAIL oct_norelease: got %h, required %h", octave, 4'(exp_oct));
    end
    release_ext(8'h75);
    for (int i = 1; i <= 10; i++) begin
      arrow_down();
      release_ext(8'h72);
    end
    vectors++;
    if (octave !== 4'hC) begin
      miscompares++; $display("FAIL oct_min: got %h, required C", octave);
    end
    arrow_up();
    release_ext(8'h75);
    vectors++;
    if (octave !== 4'(exp_oct)) begin
      miscompares++; $display("FAIL oct_from_min: got %h, required %h", octave, 4'(exp_oct));
    end
  endtask

  task automatic test_flat_sharp();
    press_ext(8'h6B);
    release_ext(8'h6B);
    press_ext(8'h74);
    exp_flat = 1'b1; exp_sharp = 1'b1;
    vectors++;
    if ({flat, sharp} !== {exp_flat, exp_sharp}) begin
      miscompares++; $display("FAIL fs_set: got flat=%b sharp=%b, required 1 1", flat, sharp);
    end
    press_ext(8'h74);
    press_ext(8'h6B);
    release_ext(8'h6B);
    exp_flat = 1'b0;
    vectors++;
    if ({flat, sharp} !== {exp_flat, exp_sharp}) begin
      miscompares++; $display("FAIL fs_toggle: got flat=%b sharp=%b, required 0 1", flat, sharp);
    end
    release_ext(8'h74);
  endtask

  task automatic test_timeout();
    int drop_at;
    send_byte(8'hE0);
    repeat (T / 2) @(negedge clk);
    vectors++;
    if (prefix_pending !== 1'b1) begin
      miscompares++; $display("FAIL to_midway: got %b, required 1", prefix_pending);
    end
    // duplicate prefix restarts the wait
    send_byte(8'hE0);
    drop_at = 0;
    for (int n = 1; n <= T + 10; n++) begin
      @(negedge clk);
      if (!prefix_pending) begin
        drop_at = n;
        break;
      end
    end
    vectors++;
    if (drop_at != T) begin
      miscompares++; $display("FAIL to_drop_cycle: got %0d, required %0d", drop_at, T);
    end
    send_byte(8'h75);
    vectors++;
    if (octave !== 4'(exp_oct) || prefix_pending !== 1'b0 || {flat, sharp} !== {exp_flat, exp_sharp}) begin
      miscompares++; $display("FAIL to_stray_byte: got oct=%h pend=%b fs=%b%b, required %h 0 %b%b",
                              octave, prefix_pending, flat, sharp, 4'(exp_oct), exp_flat, exp_sharp);
    end
  endtask

  task automatic test_clear();
    exp_q.push_back({1'b0, 3'd2});
    send_byte(8'h26);
    exp_q.push_back({1'b0, 3'd5});
    send_byte(8'h36);
    vectors++;
    if (note_held !== 7'b0010010) begin
      miscompares++; $display("FAIL clr_pre: got %b, required 0010010", note_held);
    end
    press_ext(8'h74);
    exp_sharp = ~exp_sharp;
    @(negedge clk);
    clear = 1'b1;
    bus.received_data = 8'h16;
    bus.received_data_en = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bus.received_data_en = 1'b0;
    @(negedge clk);
    vectors++;
    if (note_held !== 7'b0000000 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL clr_held: got %b pending_exp=%0d, required 0000000 0", note_held, exp_q.size());
    end
    vectors++;
    if (octave !== 4'(exp_oct) || {flat, sharp} !== {exp_flat, exp_sharp}) begin
      miscompares++; $display("FAIL clr_retain: got oct=%h fs=%b%b, required %h %b%b",
                              octave, flat, sharp, 4'(exp_oct), exp_flat, exp_sharp);
    end
    // arrow_held cleared: right toggles again without a break
    press_ext(8'h74);
    exp_sharp = ~exp_sharp;
    vectors++;
    if (sharp !== exp_sharp) begin
      miscompares++; $display("FAIL clr_arrow: got %b, required %b", sharp, exp_sharp);
    end
    exp_q.push_back({1'b0, 3'd2});
    send_byte(8'h26);
    vectors++;
    if (note_held !== 7'b0010000) begin
      miscompares++; $display("FAIL clr_remake: got %b, required 0010000", note_held);
    end
  endtask

  task automatic test_reset_midseq();
    send_byte(8'hF0);
    resetn = 1'b0;
    #1;
    vectors++;
    if ({note_held, note_on, note_off, note_idx, octave, flat, sharp, prefix_pending} !== 20'h0) begin
      miscompares++;
      $display("FAIL rst_mid: got held=%b on=%b off=%b idx=%0d oct=%h flat=%b sharp=%b pend=%b, required all 0",
               note_held, note_on, note_off, note_idx, octave, flat, sharp, prefix_pending);
    end
    exp_q.delete();
    exp_oct = 0; exp_flat = 1'b0; exp_sharp = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    exp_q.push_back({1'b0, 3'd0});
    send_byte(8'h16);
    vectors++;
    if (note_held !== 7'b1000000) begin
      miscompares++; $display("FAIL rst_idle_make: got %b, required 1000000", note_held);
    end
    exp_q.push_back({1'b1, 3'd0});
    release_note(8'h16);
    @(negedge clk);
    vectors++;
    if (note_held !== 7'b0000000 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL rst_final: got %b pending_exp=%0d, required 0000000 0", note_held, exp_q.size());
    end
  endtask

  initial begin
    bus.received_data = 8'h00;
    bus.received_data_en = 1'b0;
    test_reset();
    test_typematic();
    test_multi_notes();
    test_back_to_back();
    test_octave();
    test_flat_sharp();
    test_timeout();
    test_clear();
    test_reset_midseq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
